// File: rtl/rvga_mem_arbiter_pkg.sv
// Shared types for the I/D memory-port arbiter.
// Line/word typedefs, arbiter state, requester ids and request bundle.
package rvga_mem_arbiter_pkg;

    typedef logic [31:0]  rvga_word;
    typedef logic [127:0] rvga_cacheline;

    parameter int unsigned RVGA_LINE_OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } rvga_arb_state_e;

    typedef enum logic {
        e_rvga_req_i = 1'b0,
        e_rvga_req_d = 1'b1
    } rvga_requester_e;

    typedef struct packed {
        rvga_word      addr;
        logic          we;
        rvga_cacheline wdata;
    } rvga_mem_req_s;

    function automatic rvga_word rvga_line_align(
        input rvga_word    a,
        input int unsigned off
    );
        rvga_word mask;
        mask = (rvga_word'(1) << off) - rvga_word'(1);
        return a & ~mask;
    endfunction

endpackage

// File: rtl/rvga_rr_arb2.sv
// Two-way round-robin grant; bit 0 = I-side, bit 1 = D-side.
// last_grant only advances when the grant is actually taken (en_i).
module rvga_rr_arb2
    import rvga_mem_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    rvga_requester_e last_grant_q;
    rvga_requester_e last_grant_d;

    always_comb begin
        gnt_o        = req_i;
        last_grant_d = last_grant_q;
        if (req_i == 2'b11) begin
            if (last_grant_q == e_rvga_req_i) begin
                gnt_o = 2'b10;
            end else begin
                gnt_o = 2'b01;
            end
        end
        if (en_i && gnt_o[1]) begin
            last_grant_d = e_rvga_req_d;
        end else if (en_i && gnt_o[0]) begin
            last_grant_d = e_rvga_req_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            last_grant_q <= e_rvga_req_i;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/rvga_mem_arbiter.sv
// Serialises I-fetch and load/store line requests onto one memory port.
// One transaction outstanding; responses are routed back to the owner.
module rvga_mem_arbiter
    import rvga_mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES   = 1024,
    parameter int unsigned LINE_OFFSET_BITS = RVGA_LINE_OFFSET_BITS
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          i_req_v_i,
    input  logic [31:0]   i_addr_i,
    output logic          i_ready_o,
    output logic          i_resp_v_o,
    output logic [127:0]  i_rdata_o,
    input  logic          d_req_v_i,
    input  logic [31:0]   d_addr_i,
    input  logic          d_we_i,
    input  logic [127:0]  d_wdata_i,
    output logic          d_ready_o,
    output logic          d_resp_v_o,
    output logic [127:0]  d_rdata_o,
    output logic          mem_req_v_o,
    output logic [31:0]   mem_addr_o,
    output logic          mem_we_o,
    output logic [127:0]  mem_wdata_o,
    input  logic          mem_ready_i,
    input  logic          mem_resp_v_i,
    input  logic [127:0]  mem_rdata_i,
    output logic          protocol_err_o
);

    rvga_arb_state_e state_q, state_d;
    rvga_requester_e owner_q, owner_d;
    rvga_mem_req_s   req_q, req_d;
    logic            mem_req_v_q, mem_req_v_d;
    logic            i_resp_v_q, i_resp_v_d;
    logic            d_resp_v_q, d_resp_v_d;
    rvga_cacheline   i_rdata_q, i_rdata_d;
    rvga_cacheline   d_rdata_q, d_rdata_d;
    logic            err_q, err_d;
    logic [31:0]     tmo_cnt_q, tmo_cnt_d;

    logic [1:0] gnt;
    logic       arb_en;

    assign arb_en = rst_n_i && (state_q == IDLE);

    rvga_rr_arb2 u_arb (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .req_i   ({d_req_v_i, i_req_v_i}),
        .en_i    (arb_en),
        .gnt_o   (gnt)
    );

    assign i_ready_o = arb_en && gnt[0];
    assign d_ready_o = arb_en && gnt[1];

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        req_d       = req_q;
        mem_req_v_d = mem_req_v_q;
        i_resp_v_d  = 1'b0;
        d_resp_v_d  = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        err_d       = err_q;
        tmo_cnt_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (d_ready_o) begin
                    req_d.addr  = rvga_line_align(d_addr_i, LINE_OFFSET_BITS);
                    req_d.we    = d_we_i;
                    req_d.wdata = d_wdata_i;
                    owner_d     = e_rvga_req_d;
                end else if (i_ready_o) begin
                    req_d.addr  = rvga_line_align(i_addr_i, LINE_OFFSET_BITS);
                    req_d.we    = 1'b0;
                    req_d.wdata = '0;
                    owner_d     = e_rvga_req_i;
                end
                if (d_ready_o || i_ready_o) begin
                    mem_req_v_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // a response before the handshake completes is dropped
                if (mem_resp_v_i) begin
                    err_d = 1'b1;
                end
                if (mem_ready_i) begin
                    mem_req_v_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_v_i) begin
                    state_d = IDLE;
                    if (owner_q == e_rvga_req_d) begin
                        d_resp_v_d = 1'b1;
                        if (!req_q.we) begin
                            d_rdata_d = mem_rdata_i;
                        end
                    end else begin
                        i_resp_v_d = 1'b1;
                        i_rdata_d  = mem_rdata_i;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q;
                    if (tmo_cnt_q != '1) begin
                        tmo_cnt_d = tmo_cnt_q + 32'd1;
                    end
                    if (TIMEOUT_CYCLES != 0 && tmo_cnt_d == TIMEOUT_CYCLES) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            owner_q     <= e_rvga_req_i;
            req_q       <= '0;
            mem_req_v_q <= 1'b0;
            i_resp_v_q  <= 1'b0;
            d_resp_v_q  <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            req_q       <= req_d;
            mem_req_v_q <= mem_req_v_d;
            i_resp_v_q  <= i_resp_v_d;
            d_resp_v_q  <= d_resp_v_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign mem_req_v_o    = mem_req_v_q;
    assign mem_addr_o     = req_q.addr;
    assign mem_we_o       = req_q.we;
    assign mem_wdata_o    = req_q.wdata;
    assign i_resp_v_o     = i_resp_v_q;
    assign i_rdata_o      = i_rdata_q;
    assign d_resp_v_o     = d_resp_v_q;
    assign d_rdata_o      = d_rdata_q;
    assign protocol_err_o = err_q;

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// Scoreboarded bench for rvga_mem_arbiter: grants and responses are
// queued by the stimulus and checked by a negedge monitor.
module tb_rvga_mem_arbiter;

    logic         clk;
    logic         rst_n;
    logic         i_req_v;
    logic [31:0]  i_addr;
    logic         i_ready_o;
    logic         i_resp_v_o;
    logic [127:0] i_rdata_o;
    logic         d_req_v;
    logic [31:0]  d_addr;
    logic         d_we;
    logic [127:0] d_wdata;
    logic         d_ready_o;
    logic         d_resp_v_o;
    logic [127:0] d_rdata_o;
    logic         mem_req_v_o;
    logic [31:0]  mem_addr_o;
    logic         mem_we_o;
    logic [127:0] mem_wdata_o;
    logic         mem_ready;
    logic         mem_resp_v;
    logic [127:0] mem_rdata;
    logic         protocol_err_o;

    rvga_mem_arbiter #(
        .TIMEOUT_CYCLES   (8),
        .LINE_OFFSET_BITS (4)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .i_req_v_i      (i_req_v),
        .i_addr_i       (i_addr),
        .i_ready_o      (i_ready_o),
        .i_resp_v_o     (i_resp_v_o),
        .i_rdata_o      (i_rdata_o),
        .d_req_v_i      (d_req_v),
        .d_addr_i       (d_addr),
        .d_we_i         (d_we),
        .d_wdata_i      (d_wdata),
        .d_ready_o      (d_ready_o),
        .d_resp_v_o     (d_resp_v_o),
        .d_rdata_o      (d_rdata_o),
        .mem_req_v_o    (mem_req_v_o),
        .mem_addr_o     (mem_addr_o),
        .mem_we_o       (mem_we_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_ready_i    (mem_ready),
        .mem_resp_v_i   (mem_resp_v),
        .mem_rdata_i    (mem_rdata),
        .protocol_err_o (protocol_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         side;
        logic [127:0] data;
    } resp_t;

    resp_t resp_q[$];
    logic  grant_q[$];
    int    checks   = 0;
    int    failures = 0;

    localparam logic [127:0] DA5  = {16{8'hA5}};
    localparam logic [127:0] DAT1 = 128'h1111_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [127:0] DAT2 = 128'h2222_0000_0000_0000_0000_0000_0000_0002;
    localparam logic [127:0] DAT3 = 128'h3333_0000_0000_0000_0000_0000_0000_0003;
    localparam logic [127:0] DAT4 = 128'h4444_0000_0000_0000_0000_0000_0000_0004;
    localparam logic [127:0] DAT5 = 128'h5555_0000_0000_0000_0000_0000_0000_0005;
    localparam logic [127:0] DAT6 = 128'h6666_0000_0000_0000_0000_0000_0000_0006;
    localparam logic [127:0] DAT7 = 128'h7777_0000_0000_0000_0000_0000_0000_0007;
    localparam logic [127:0] DAT8 = 128'h8888_0000_0000_0000_0000_0000_0000_0008;
    localparam logic [127:0] DAT9 = 128'h9999_0000_0000_0000_0000_0000_0000_0009;
    localparam logic [127:0] DATA = 128'hAAAA_0000_0000_0000_0000_0000_0000_000A;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // memory model: optional backpressure, then response one cycle later
    task automatic serve(input int stall, input logic [127:0] data,
                         input logic [31:0] ea, input logic ewe,
                         input logic [127:0] ewd, input string nm);
        int w;
        w = 0;
        while (!mem_req_v_o && w < 20) begin
            tick();
            w++;
        end
        chk({nm, "_req_latency"}, 128'(w), 128'd0);
        chk({nm, "_addr"}, 128'(mem_addr_o), 128'(ea));
        chk({nm, "_we"}, 128'(mem_we_o), 128'(ewe));
        chk({nm, "_wdata"}, mem_wdata_o, ewd);
        for (int s = 0; s < stall; s++) begin
            mem_ready = 1'b0;
            tick();
            chk({nm, "_stall_req_v"}, 128'(mem_req_v_o), 128'd1);
            chk({nm, "_stall_addr"}, 128'(mem_addr_o), 128'(ea));
            chk({nm, "_stall_wdata"}, mem_wdata_o, ewd);
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk({nm, "_req_dropped"}, 128'(mem_req_v_o), 128'd0);
        mem_resp_v = 1'b1;
        mem_rdata  = data;
        tick();
        mem_resp_v = 1'b0;
        mem_rdata  = '0;
    endtask

    logic i_prev_req = 1'b0;
    logic i_prev_rdy = 1'b0;
    logic d_prev_req = 1'b0;
    logic d_prev_rdy = 1'b0;

    always @(negedge clk) begin
        resp_t r;
        if (i_ready_o || d_ready_o) begin
            chk("ready_both", 128'(i_ready_o & d_ready_o), 128'd0);
            if (grant_q.size() == 0) begin
                chk("grant_unexpected", 128'd1, 128'd0);
            end else begin
                chk("grant_side", 128'(d_ready_o), 128'(grant_q.pop_front()));
            end
        end
        if (i_resp_v_o) begin
            if (resp_q.size() == 0) begin
                chk("i_resp_unexpected", 128'd1, 128'd0);
            end else begin
                r = resp_q.pop_front();
                chk("i_resp_side", 128'd0, 128'(r.side));
                chk("i_rdata", i_rdata_o, r.data);
            end
        end
        if (d_resp_v_o) begin
            if (resp_q.size() == 0) begin
                chk("d_resp_unexpected", 128'd1, 128'd0);
            end else begin
                r = resp_q.pop_front();
                chk("d_resp_side", 128'd1, 128'(r.side));
                chk("d_rdata", d_rdata_o, r.data);
            end
        end
        if (rst_n && i_prev_req && !i_prev_rdy) begin
            chk("i_req_held", 128'(i_req_v), 128'd1);
        end
        if (rst_n && d_prev_req && !d_prev_rdy) begin
            chk("d_req_held", 128'(d_req_v), 128'd1);
        end
        i_prev_req = i_req_v;
        i_prev_rdy = i_ready_o;
        d_prev_req = d_req_v;
        d_prev_rdy = d_ready_o;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        i_req_v    = 1'b0;
        i_addr     = '0;
        d_req_v    = 1'b0;
        d_addr     = '0;
        d_we       = 1'b0;
        d_wdata    = '0;
        mem_ready  = 1'b0;
        mem_resp_v = 1'b0;
        mem_rdata  = '0;
        repeat (2) tick();

        // ready stays low while reset is held
        i_req_v = 1'b1;
        d_req_v = 1'b1;
        #1;
        chk("rst_i_ready", 128'(i_ready_o), 128'd0);
        chk("rst_d_ready", 128'(d_ready_o), 128'd0);
        i_req_v = 1'b0;
        d_req_v = 1'b0;
        chk("rst_mem_req_v", 128'(mem_req_v_o), 128'd0);
        chk("rst_mem_addr", 128'(mem_addr_o), 128'd0);
        chk("rst_err", 128'(protocol_err_o), 128'd0);
        chk("rst_i_resp", 128'(i_resp_v_o), 128'd0);
        chk("rst_d_rdata", d_rdata_o, 128'd0);
        rst_n = 1'b1;

        // I-only read
        i_req_v = 1'b1;
        i_addr  = 32'h0001005C;
        grant_q.push_back(1'b0);
        resp_q.push_back('{1'b0, DA5});
        #1;
        chk("iread_ready_c0", 128'(i_ready_o), 128'd1);
        tick();
        i_req_v = 1'b0;
        serve(0, DA5, 32'h00010050, 1'b0, 128'd0, "iread");
        chk("iread_resp_c3", 128'(i_resp_v_o), 128'd1);
        chk("iread_no_d_resp", 128'(d_resp_v_o), 128'd0);

        // tie: D wins (last grant was I), then alternate
        d_addr  = 32'h20000048;
        d_wdata = 128'h77;
        i_addr  = 32'h10000024;
        i_req_v = 1'b1;
        d_req_v = 1'b1;
        grant_q.push_back(1'b1);
        grant_q.push_back(1'b0);
        grant_q.push_back(1'b1);
        grant_q.push_back(1'b0);
        resp_q.push_back('{1'b1, DAT1});
        resp_q.push_back('{1'b0, DAT2});
        resp_q.push_back('{1'b1, DAT3});
        resp_q.push_back('{1'b0, DAT4});
        tick();
        serve(0, DAT1, 32'h20000040, 1'b0, 128'h77, "tie1");
        tick();
        serve(0, DAT2, 32'h10000020, 1'b0, 128'd0, "tie2");
        tick();
        d_req_v = 1'b0;
        serve(0, DAT3, 32'h20000040, 1'b0, 128'h77, "tie3");
        tick();
        i_req_v = 1'b0;
        serve(0, DAT4, 32'h10000020, 1'b0, 128'd0, "tie4");

        // D write under 5 cycles of backpressure; d_rdata keeps DAT3
        d_req_v = 1'b1;
        d_we    = 1'b1;
        d_wdata = 128'h1234;
        d_addr  = 32'h00003008;
        grant_q.push_back(1'b1);
        resp_q.push_back('{1'b1, DAT3});
        tick();
        d_req_v = 1'b0;
        d_we    = 1'b0;
        serve(5, 128'hDEAD, 32'h00003000, 1'b1, 128'h1234, "dwr");
        chk("dwr_resp", 128'(d_resp_v_o), 128'd1);

        // timeout after 8 WAIT cycles, then a late response
        i_req_v = 1'b1;
        i_addr  = 32'h00040010;
        grant_q.push_back(1'b0);
        tick();
        i_req_v = 1'b0;
        chk("tmo_issue", 128'(mem_req_v_o), 128'd1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        repeat (7) tick();
        chk("tmo_err_before", 128'(protocol_err_o), 128'd0);
        tick();
        chk("tmo_err_set", 128'(protocol_err_o), 128'd1);
        repeat (3) tick();
        chk("tmo_err_sticky", 128'(protocol_err_o), 128'd1);
        resp_q.push_back('{1'b0, DAT5});
        mem_resp_v = 1'b1;
        mem_rdata  = DAT5;
        tick();
        mem_resp_v = 1'b0;
        mem_rdata  = '0;
        chk("tmo_late_resp", 128'(i_resp_v_o), 128'd1);
        chk("tmo_err_after", 128'(protocol_err_o), 128'd1);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst2_err", 128'(protocol_err_o), 128'd0);
        chk("rst2_i_rdata", i_rdata_o, 128'd0);

        // early response while in ISSUE
        i_req_v = 1'b1;
        i_addr  = 32'h00050000;
        grant_q.push_back(1'b0);
        tick();
        i_req_v    = 1'b0;
        mem_resp_v = 1'b1;
        mem_rdata  = DAT6;
        tick();
        mem_resp_v = 1'b0;
        mem_rdata  = '0;
        chk("early_err", 128'(protocol_err_o), 128'd1);
        chk("early_still_issue", 128'(mem_req_v_o), 128'd1);
        chk("early_no_resp", 128'(i_resp_v_o), 128'd0);
        resp_q.push_back('{1'b0, DAT7});
        serve(0, DAT7, 32'h00050000, 1'b0, 128'd0, "early");
        chk("early_err_sticky", 128'(protocol_err_o), 128'd1);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // reset in WAIT abandons the D read
        d_req_v = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h00060004;
        d_wdata = 128'h99;
        grant_q.push_back(1'b1);
        tick();
        d_req_v   = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rstw_mem_req_v", 128'(mem_req_v_o), 128'd0);
        chk("rstw_mem_addr", 128'(mem_addr_o), 128'd0);
        chk("rstw_mem_we", 128'(mem_we_o), 128'd0);
        chk("rstw_mem_wdata", mem_wdata_o, 128'd0);
        chk("rstw_err", 128'(protocol_err_o), 128'd0);
        chk("rstw_d_resp", 128'(d_resp_v_o), 128'd0);
        mem_resp_v = 1'b1;
        mem_rdata  = DAT8;
        tick();
        mem_resp_v = 1'b0;
        mem_rdata  = '0;
        tick();
        chk("stale_err", 128'(protocol_err_o), 128'd0);
        chk("stale_d_resp", 128'(d_resp_v_o), 128'd0);
        chk("stale_d_rdata", d_rdata_o, 128'd0);

        // first tie after reset goes to D
        i_addr  = 32'h10000024;
        d_addr  = 32'h20000048;
        i_req_v = 1'b1;
        d_req_v = 1'b1;
        grant_q.push_back(1'b1);
        grant_q.push_back(1'b0);
        resp_q.push_back('{1'b1, DAT9});
        resp_q.push_back('{1'b0, DATA});
        #1;
        chk("rtie_d_ready", 128'(d_ready_o), 128'd1);
        chk("rtie_i_ready", 128'(i_ready_o), 128'd0);
        tick();
        d_req_v = 1'b0;
        serve(0, DAT9, 32'h20000040, 1'b0, 128'h99, "rtie_d");
        tick();
        i_req_v = 1'b0;
        serve(0, DATA, 32'h10000020, 1'b0, 128'd0, "rtie_i");

        repeat (3) tick();
        chk("grant_q_empty", 128'(grant_q.size()), 128'd0);
        chk("resp_q_empty", 128'(resp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
